// File: rtl/regfile_dump.sv
// regfile_dump: register file with two combinational read ports, one write port,
// a sticky program-end flag and a handshaked streamer that emits every register
// in index order. Register 0 always reads as zero and is never written.
module regfile_dump #(
   parameter int WIDTH     = 32,
   parameter int NREGS     = 32,
   parameter int IDXW      = 5,
   parameter int AUTO_DUMP = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [IDXW-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [IDXW-1:0]  raddr1,
   input  logic [IDXW-1:0]  raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   input  logic [31:0]      instrucao,
   input  logic             dump_req,
   input  logic             dump_ready,
   output logic             dump_valid,
   output logic [IDXW-1:0]  dump_idx,
   output logic [WIDTH-1:0] dump_data,
   output logic             dump_busy,
   output logic             dump_done,
   output logic             halted
);

   // Register count widened by one bit so NREGS == 2**IDXW still compares correctly.
   localparam logic [IDXW:0]   NREGS_EXT = (IDXW+1)'(NREGS);
   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDXW-1:0]  ptr;
   logic [IDXW-1:0]  ptr_next;
   logic [WIDTH-1:0] regs [NREGS];

   logic             wr_ok;
   logic             halt_now;
   logic             start_dump;

   // An index names a real, writable register: not zero and below NREGS.
   function automatic logic in_range(input logic [IDXW-1:0] idx);
      return (idx != '0) && ({1'b0, idx} < NREGS_EXT);
   endfunction

   // A write only lands while running; once halted the file is frozen so the
   // dump reflects the state at program end.
   assign wr_ok      = we && !halted && in_range(waddr);
   assign halt_now   = !halted && (instrucao == 32'd0);
   assign start_dump = dump_req || ((AUTO_DUMP != 0) && halt_now);

   // Register storage: cleared on reset, otherwise updated by qualified writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

   // Sticky program-end flag, raised by the first all-zero instruction word.
   always_ff @(posedge clock) begin
      if (reset) begin
         halted <= 1'b0;
      end else if (halt_now) begin
         halted <= 1'b1;
      end
   end

   // Read port 1: zero for register 0 or out-of-range, same-cycle write bypass otherwise.
   always_comb begin
      rdata1 = '0;
      if (in_range(raddr1)) begin
         if (wr_ok && (raddr1 == waddr)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = regs[raddr1];
         end
      end
   end

   // Read port 2: identical behaviour to port 1.
   always_comb begin
      rdata2 = '0;
      if (in_range(raddr2)) begin
         if (wr_ok && (raddr2 == waddr)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = regs[raddr2];
         end
      end
   end

   // Streamer state and beat pointer register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // Streamer next-state and handshake outputs; requests outside IDLE are dropped.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_done  = 1'b0;
      dump_idx   = '0;
      case (state)
         IDLE: begin
            if (start_dump) begin
               state_next = DUMP;
               ptr_next   = '0;
            end
         end
         DUMP: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            dump_idx   = ptr;
            if (dump_ready) begin
               if (ptr == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  ptr_next = ptr + IDXW'(1);
               end
            end
         end
         DONE: begin
            dump_done  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Beat data is the stored value only; register 0 is held at zero so it streams 0.
   always_comb begin
      dump_data = '0;
      if (state == DUMP) begin
         dump_data = regs[ptr];
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized and directed stimulus for regfile_dump, checked
// every cycle against a behavioural model plus directed literal expectations.
module tb_regfile_dump;

   localparam int WIDTH     = 32;
   localparam int NREGS     = 32;
   localparam int IDXW      = 5;
   localparam int AUTO_DUMP = 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             we;
   logic [IDXW-1:0]  waddr;
   logic [WIDTH-1:0] wdata;
   logic [IDXW-1:0]  raddr1;
   logic [IDXW-1:0]  raddr2;
   logic [WIDTH-1:0] rdata1;
   logic [WIDTH-1:0] rdata2;
   logic [31:0]      instrucao;
   logic             dump_req;
   logic             dump_ready;
   logic             dump_valid;
   logic [IDXW-1:0]  dump_idx;
   logic [WIDTH-1:0] dump_data;
   logic             dump_busy;
   logic             dump_done;
   logic             halted;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   logic [WIDTH-1:0] m_regs [NREGS];
   logic             m_halted  = 1'b0;
   logic             m_dumping = 1'b0;
   logic             m_done    = 1'b0;
   int               m_ptr     = 0;
   logic             m_valid   = 1'b0;
   logic             m_halt_now;

   regfile_dump #(
      .WIDTH(WIDTH),
      .NREGS(NREGS),
      .IDXW(IDXW),
      .AUTO_DUMP(AUTO_DUMP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr1(raddr1),
      .raddr2(raddr2),
      .rdata1(rdata1),
      .rdata2(rdata2),
      .instrucao(instrucao),
      .dump_req(dump_req),
      .dump_ready(dump_ready),
      .dump_valid(dump_valid),
      .dump_idx(dump_idx),
      .dump_data(dump_data),
      .dump_busy(dump_busy),
      .dump_done(dump_done),
      .halted(halted)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic w, input logic [IDXW-1:0] wa,
                                input logic [WIDTH-1:0] wd, input logic dreq, input logic rdy);
      reset      = rst;
      we         = w;
      waddr      = wa;
      wdata      = wd;
      dump_req   = dreq;
      dump_ready = rdy;
   endtask

   task automatic stepCycle;
      @(posedge clock);
      #1;
   endtask

   // What a read port must return given the architectural rules.
   function automatic logic [WIDTH-1:0] modelRead(input logic [IDXW-1:0] idx);
      if (idx == '0 || int'(idx) >= NREGS) return '0;
      if (we && !m_halted && idx == waddr) return wdata;
      return m_regs[idx];
   endfunction

   // Compare DUT against the model mid-cycle, then advance the model across the coming edge.
   always @(negedge clock) begin
      if (m_valid) begin
         checkOutput("rdata1", 64'(rdata1), 64'(modelRead(raddr1)));
         checkOutput("rdata2", 64'(rdata2), 64'(modelRead(raddr2)));
         checkOutput("dump_valid", 64'(dump_valid), 64'(m_dumping));
         checkOutput("dump_busy", 64'(dump_busy), 64'(m_dumping));
         checkOutput("dump_done", 64'(dump_done), 64'(m_done));
         checkOutput("halted", 64'(halted), 64'(m_halted));
         if (m_dumping) begin
            checkOutput("dump_idx", 64'(dump_idx), 64'(m_ptr));
            checkOutput("dump_data", 64'(dump_data), 64'(m_regs[m_ptr]));
         end
      end
      if (reset) begin
         for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
         m_halted  = 1'b0;
         m_dumping = 1'b0;
         m_done    = 1'b0;
         m_ptr     = 0;
         m_valid   = 1'b1;
      end else begin
         m_halt_now = !m_halted && (instrucao == 32'd0);
         if (m_dumping) begin
            if (dump_ready) begin
               if (m_ptr == NREGS - 1) begin
                  m_dumping = 1'b0;
                  m_done    = 1'b1;
               end else begin
                  m_ptr = m_ptr + 1;
               end
            end
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (dump_req || (AUTO_DUMP != 0 && m_halt_now)) begin
            m_dumping = 1'b1;
            m_ptr     = 0;
         end
         if (we && !m_halted && waddr != '0 && int'(waddr) < NREGS) m_regs[waddr] = wdata;
         if (m_halt_now) m_halted = 1'b1;
      end
   end

   // Directed scenarios followed by a randomized phase.
   initial begin
      int k;
      int nbeats;
      logic [IDXW-1:0] wa;

      instrucao = 32'h0000_0013;
      raddr1    = IDXW'(5);
      raddr2    = '0;
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      stepCycle;
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("rst_dump_valid", 64'(dump_valid), 64'd0);
      checkOutput("rst_dump_idx", 64'(dump_idx), 64'd0);
      checkOutput("rst_dump_data", 64'(dump_data), 64'd0);
      checkOutput("rst_dump_busy", 64'(dump_busy), 64'd0);
      checkOutput("rst_dump_done", 64'(dump_done), 64'd0);
      checkOutput("rst_halted", 64'(halted), 64'd0);
      checkOutput("rst_rdata1", 64'(rdata1), 64'd0);
      checkOutput("rst_rdata2", 64'(rdata2), 64'd0);
      stepCycle;

      // Basic writes, register 0 immunity and same-cycle bypass.
      applyStimulus(1'b0, 1'b1, IDXW'(5), 32'h0000_00AA, 1'b0, 1'b0);
      stepCycle;
      applyStimulus(1'b0, 1'b1, IDXW'(0), 32'h0000_1234, 1'b0, 1'b0);
      stepCycle;
      applyStimulus(1'b0, 1'b1, IDXW'(7), 32'h0000_0055, 1'b0, 1'b0);
      raddr1 = IDXW'(7);
      raddr2 = IDXW'(0);
      #1;
      checkOutput("bypass_r7", 64'(rdata1), 64'h55);
      checkOutput("read_r0_during_w", 64'(rdata2), 64'h0);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      raddr1 = IDXW'(5);
      raddr2 = IDXW'(0);
      #1;
      checkOutput("read_r5", 64'(rdata1), 64'hAA);
      checkOutput("read_r0", 64'(rdata2), 64'h0);
      raddr2 = IDXW'(7);
      #1;
      checkOutput("read_r7", 64'(rdata2), 64'h55);
      stepCycle;

      // Full dump with the consumer always ready.
      for (int i = 1; i < NREGS; i++) begin
         applyStimulus(1'b0, 1'b1, IDXW'(i), WIDTH'(i * 3), 1'b0, 1'b1);
         stepCycle;
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      k = 1;
      nbeats = 0;
      while (!dump_done && k < 100) begin
         if (dump_valid) begin
            checkOutput("beat_idx", 64'(dump_idx), 64'(nbeats));
            checkOutput("beat_data", 64'(dump_data), 64'(nbeats * 3));
            nbeats++;
         end
         stepCycle;
         k++;
      end
      checkOutput("full_done_cycle", 64'(k), 64'd33);
      checkOutput("full_beat_count", 64'(nbeats), 64'd32);
      stepCycle;
      checkOutput("after_done_idle", 64'(dump_done | dump_valid), 64'd0);

      // Dump with the consumer alternating ready/not-ready.
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      k = 1;
      nbeats = 0;
      while (!dump_done && k < 200) begin
         dump_ready = k[0];
         if (dump_valid && dump_ready) begin
            checkOutput("stall_idx", 64'(dump_idx), 64'(nbeats));
            nbeats++;
         end
         stepCycle;
         k++;
      end
      checkOutput("stall_done_cycle", 64'(k), 64'd64);
      checkOutput("stall_beat_count", 64'(nbeats), 64'd32);
      stepCycle;

      // Randomized traffic with occasional dump requests and rare resets.
      for (int c = 0; c < 600; c++) begin
         wa        = IDXW'($urandom_range(0, 31));
         raddr1    = ($urandom_range(0, 3) == 0) ? wa : IDXW'($urandom_range(0, 31));
         raddr2    = IDXW'($urandom_range(0, 31));
         instrucao = $urandom | 32'h1;
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
         stepCycle;
      end

      // Program end: auto dump starts, further writes are ignored.
      instrucao = 32'h0000_0013;
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      stepCycle;
      applyStimulus(1'b0, 1'b1, IDXW'(3), 32'h0000_0033, 1'b0, 1'b0);
      stepCycle;
      instrucao = 32'h0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      stepCycle;
      instrucao = 32'h0000_0013;
      checkOutput("halt_set", 64'(halted), 64'd1);
      checkOutput("auto_dump_busy", 64'(dump_busy), 64'd1);
      checkOutput("auto_dump_idx", 64'(dump_idx), 64'd0);
      applyStimulus(1'b0, 1'b1, IDXW'(3), 32'h0000_DEAD, 1'b0, 1'b0);
      raddr1 = IDXW'(3);
      #1;
      checkOutput("halted_no_bypass", 64'(rdata1), 64'h33);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checkOutput("halted_r3_kept", 64'(rdata1), 64'h33);
      k = 0;
      while (!dump_done && k < 100) begin
         stepCycle;
         k++;
      end
      if (k >= 100) begin
         total++;
         bad++;
         $display("[TB] FAIL auto_dump_timeout: got no dump_done, expected one within 100 cycles");
      end
      stepCycle;
      checkOutput("halt_sticky", 64'(halted), 64'd1);

      // Reset in the middle of a dump aborts it silently.
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      k = 0;
      while (!(dump_valid && dump_idx == IDXW'(10)) && k < 50) begin
         stepCycle;
         k++;
      end
      if (k >= 50) begin
         total++;
         bad++;
         $display("[TB] FAIL beat10_timeout: got no beat 10, expected it within 50 cycles");
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      stepCycle;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checkOutput("abort_valid", 64'(dump_valid), 64'd0);
      checkOutput("abort_done", 64'(dump_done), 64'd0);
      checkOutput("abort_halted", 64'(halted), 64'd0);
      checkOutput("abort_busy", 64'(dump_busy), 64'd0);
      for (int i = 0; i < NREGS; i++) begin
         raddr1 = IDXW'(i);
         #1;
         checkOutput("abort_reg_zero", 64'(rdata1), 64'd0);
      end
      stepCycle;
      checkOutput("abort_no_late_done", 64'(dump_done), 64'd0);
      stepCycle;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
